// File: rtl/default_slave.sv
// rtl/default_slave.sv - AXI4 default slave answering DECERR; optional error log via `define DEFAULT_SLAVE_ERRLOG_EN
module default_slave #(
    parameter int ID_W   = 8,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    input  logic [ID_W-1:0]   ARID_SD,
    input  logic [ADDR_W-1:0] ARADDR_SD,
    input  logic [LEN_W-1:0]  ARLEN_SD,
    input  logic              ARVALID_SD,
    output logic              ARREADY_SD,
    output logic [ID_W-1:0]   RID_SD,
    output logic [DATA_W-1:0] RDATA_SD,
    output logic [1:0]        RRESP_SD,
    output logic              RLAST_SD,
    output logic              RVALID_SD,
    input  logic              RREADY_SD,
    input  logic [ID_W-1:0]   AWID_SD,
    input  logic [ADDR_W-1:0] AWADDR_SD,
    input  logic [LEN_W-1:0]  AWLEN_SD,
    input  logic              AWVALID_SD,
    output logic              AWREADY_SD,
    input  logic [DATA_W-1:0] WDATA_SD,
    input  logic              WLAST_SD,
    input  logic              WVALID_SD,
    output logic              WREADY_SD,
    output logic [ID_W-1:0]   BID_SD,
    output logic [1:0]        BRESP_SD,
    output logic              BVALID_SD,
    input  logic              BREADY_SD
`ifdef DEFAULT_SLAVE_ERRLOG_EN
    ,
    output logic [ADDR_W-1:0] ERR_ADDR,
    output logic [7:0]        ERR_CNT
`endif
);

    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic {R_IDLE, R_DATA} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

    r_state_t         r_state_q, r_state_d;
    logic [ID_W-1:0]  rid_q, rid_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] beat_cnt_q, beat_cnt_d;
    w_state_t         w_state_q, w_state_d;
    logic [ID_W-1:0]  bid_q, bid_d;

    logic ar_hs;
    logic aw_hs;
    logic r_last;

    // Handshake strobes and outputs decoded purely from the state registers
    assign ARREADY_SD = (r_state_q == R_IDLE);
    assign RVALID_SD  = (r_state_q == R_DATA);
    assign r_last     = (beat_cnt_q == len_q);
    assign RLAST_SD   = RVALID_SD && r_last;
    assign RID_SD     = RVALID_SD ? rid_q : '0;
    assign RRESP_SD   = RVALID_SD ? RESP_DECERR : 2'b00;
    assign RDATA_SD   = '0;

    assign AWREADY_SD = (w_state_q == W_IDLE);
    assign WREADY_SD  = (w_state_q == W_DATA);
    assign BVALID_SD  = (w_state_q == W_RESP);
    assign BID_SD     = BVALID_SD ? bid_q : '0;
    assign BRESP_SD   = BVALID_SD ? RESP_DECERR : 2'b00;

    assign ar_hs = ARVALID_SD && ARREADY_SD;
    assign aw_hs = AWVALID_SD && AWREADY_SD;

    // Read path: accept one address, then stream LEN+1 DECERR beats
    always_comb begin
        r_state_d  = r_state_q;
        rid_d      = rid_q;
        len_d      = len_q;
        beat_cnt_d = beat_cnt_q;
        case (r_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    rid_d      = ARID_SD;
                    len_d      = ARLEN_SD;
                    beat_cnt_d = '0;
                    r_state_d  = R_DATA;
                end
            end
            R_DATA: begin
                if (RREADY_SD) begin
                    if (r_last) begin
                        r_state_d = R_IDLE;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // Write path: accept address, sink data until WLAST, then one DECERR response
    always_comb begin
        w_state_d = w_state_q;
        bid_d     = bid_q;
        case (w_state_q)
            W_IDLE: begin
                if (aw_hs) begin
                    bid_d     = AWID_SD;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (WVALID_SD && WLAST_SD) begin
                    w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (BREADY_SD) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // State registers for both paths; reset abandons any in-flight burst
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state_q  <= R_IDLE;
            rid_q      <= '0;
            len_q      <= '0;
            beat_cnt_q <= '0;
            w_state_q  <= W_IDLE;
            bid_q      <= '0;
        end else begin
            r_state_q  <= r_state_d;
            rid_q      <= rid_d;
            len_q      <= len_d;
            beat_cnt_q <= beat_cnt_d;
            w_state_q  <= w_state_d;
            bid_q      <= bid_d;
        end
    end

`ifdef DEFAULT_SLAVE_ERRLOG_EN
    logic [ADDR_W-1:0] err_addr_q, err_addr_d;
    logic [7:0]        err_cnt_q, err_cnt_d;
    logic [8:0]        cnt_sum;

    // Error log: last decoded-miss address (AW has priority) and a saturating miss count
    always_comb begin
        err_addr_d = err_addr_q;
        if (aw_hs) begin
            err_addr_d = AWADDR_SD;
        end else if (ar_hs) begin
            err_addr_d = ARADDR_SD;
        end
        cnt_sum   = {1'b0, err_cnt_q} + {8'b0, ar_hs} + {8'b0, aw_hs};
        err_cnt_d = cnt_sum[8] ? 8'hFF : cnt_sum[7:0];
    end

    // Error log registers
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            err_addr_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            err_addr_q <= err_addr_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign ERR_ADDR = err_addr_q;
    assign ERR_CNT  = err_cnt_q;

    logic unused_inputs;
    assign unused_inputs = ^{WDATA_SD, AWLEN_SD};
`else
    logic unused_inputs;
    assign unused_inputs = ^{WDATA_SD, AWLEN_SD, ARADDR_SD, AWADDR_SD};
`endif

endmodule

// File: tb/tb_default_slave.sv
// tb/tb_default_slave.sv - directed self-checking bench for default_slave
module tb_default_slave;

    localparam int ID_W   = 8;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int LEN_W  = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [ID_W-1:0]   arid;
    logic [ADDR_W-1:0] araddr;
    logic [LEN_W-1:0]  arlen;
    logic              arvalid;
    logic              arready;
    logic [ID_W-1:0]   rid;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;
    logic [ID_W-1:0]   awid;
    logic [ADDR_W-1:0] awaddr;
    logic [LEN_W-1:0]  awlen;
    logic              awvalid;
    logic              awready;
    logic [DATA_W-1:0] wdata;
    logic              wlast;
    logic              wvalid;
    logic              wready;
    logic [ID_W-1:0]   bid;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
`ifdef DEFAULT_SLAVE_ERRLOG_EN
    logic [ADDR_W-1:0] err_addr;
    logic [7:0]        err_cnt;
`endif

    int checks   = 0;
    int failures = 0;
    int beats;
    int cyc;

    always #5 clk = ~clk;

    default_slave #(
        .ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)
    ) dut (
        .ACLK(clk), .ARESETn(rst_n),
        .ARID_SD(arid), .ARADDR_SD(araddr), .ARLEN_SD(arlen),
        .ARVALID_SD(arvalid), .ARREADY_SD(arready),
        .RID_SD(rid), .RDATA_SD(rdata), .RRESP_SD(rresp), .RLAST_SD(rlast),
        .RVALID_SD(rvalid), .RREADY_SD(rready),
        .AWID_SD(awid), .AWADDR_SD(awaddr), .AWLEN_SD(awlen),
        .AWVALID_SD(awvalid), .AWREADY_SD(awready),
        .WDATA_SD(wdata), .WLAST_SD(wlast), .WVALID_SD(wvalid), .WREADY_SD(wready),
        .BID_SD(bid), .BRESP_SD(bresp), .BVALID_SD(bvalid), .BREADY_SD(bready)
`ifdef DEFAULT_SLAVE_ERRLOG_EN
        ,
        .ERR_ADDR(err_addr), .ERR_CNT(err_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arvalid = 1'b0; rready = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awvalid = 1'b0;
        wdata = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        tick(); tick();

        // Reset state
        chk("rst_rvalid", rvalid, 1'b0);
        chk("rst_rlast", rlast, 1'b0);
        chk("rst_wready", wready, 1'b0);
        chk("rst_bvalid", bvalid, 1'b0);
        chk("rst_rid", rid, 8'h00);
        chk("rst_bid", bid, 8'h00);
        chk("rst_rresp", rresp, 2'b00);
        chk("rst_bresp", bresp, 2'b00);
        chk("rst_rdata", rdata, 32'h0);
        rst_n = 1'b1;
        tick();
        chk("rst_arready", arready, 1'b1);
        chk("rst_awready", awready, 1'b1);
`ifdef DEFAULT_SLAVE_ERRLOG_EN
        chk("rst_err_cnt", err_cnt, 8'h00);
        chk("rst_err_addr", err_addr, 32'h0);
`endif

        // Single read, ARLEN=0
        arid = 8'h15; arlen = 4'd0; araddr = 32'h0000_1000; arvalid = 1'b1; rready = 1'b1;
        tick();
        arvalid = 1'b0;
        chk("rd1_rvalid", rvalid, 1'b1);
        chk("rd1_rid", rid, 8'h15);
        chk("rd1_rresp", rresp, 2'b11);
        chk("rd1_rdata", rdata, 32'h0);
        chk("rd1_rlast", rlast, 1'b1);
        chk("rd1_arready_busy", arready, 1'b0);
        tick();
        chk("rd1_arready_after", arready, 1'b1);
        chk("rd1_rvalid_after", rvalid, 1'b0);

        // Burst read ARLEN=3 with RREADY toggling
        arid = 8'h33; arlen = 4'd3; arvalid = 1'b1; rready = 1'b0;
        tick();
        arvalid = 1'b0;
        beats = 0;
        cyc = 0;
        while (beats < 4 && cyc < 20) begin
            rready = (cyc % 2 == 0);
            chk("rd4_rvalid", rvalid, 1'b1);
            chk("rd4_rid", rid, 8'h33);
            chk("rd4_rresp", rresp, 2'b11);
            chk("rd4_rlast", rlast, (beats == 3));
            if (rready) beats++;
            cyc++;
            tick();
        end
        rready = 1'b0;
        chk("rd4_beats", beats, 4);
        chk("rd4_cycles", cyc, 7);
        chk("rd4_rvalid_end", rvalid, 1'b0);
        chk("rd4_arready_end", arready, 1'b1);

        // Write burst AWLEN=7, B held for 3 cycles
        awid = 8'h2A; awlen = 4'd7; awaddr = 32'h0000_2000; awvalid = 1'b1;
        chk("wr_awready", awready, 1'b1);
        chk("wr_wready_idle", wready, 1'b0);
        tick();
        awvalid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            wvalid = 1'b1; wlast = (i == 7); wdata = 32'hA500_0000 + i;
            chk("wr_wready", wready, 1'b1);
            chk("wr_bvalid_early", bvalid, 1'b0);
            chk("wr_awready_busy", awready, 1'b0);
            tick();
        end
        wvalid = 1'b0; wlast = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("wr_bvalid_hold", bvalid, 1'b1);
            chk("wr_bid", bid, 8'h2A);
            chk("wr_bresp", bresp, 2'b11);
            chk("wr_wready_resp", wready, 1'b0);
            tick();
        end
        bready = 1'b1;
        chk("wr_bvalid_accept", bvalid, 1'b1);
        tick();
        bready = 1'b0;
        chk("wr_bvalid_done", bvalid, 1'b0);
        chk("wr_awready_done", awready, 1'b1);
        chk("wr_bid_done", bid, 8'h00);

        // Concurrent read and write from a fresh reset
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
`ifdef DEFAULT_SLAVE_ERRLOG_EN
        chk("cc_err_cnt0", err_cnt, 8'h00);
`endif
        arid = 8'h01; arlen = 4'd1; araddr = 32'h0000_1111; arvalid = 1'b1; rready = 1'b1;
        awid = 8'h02; awlen = 4'd0; awaddr = 32'h0000_2222; awvalid = 1'b1; bready = 1'b0;
        tick();
        arvalid = 1'b0; awvalid = 1'b0;
        chk("cc_rvalid0", rvalid, 1'b1);
        chk("cc_rid0", rid, 8'h01);
        chk("cc_rlast0", rlast, 1'b0);
        chk("cc_wready", wready, 1'b1);
`ifdef DEFAULT_SLAVE_ERRLOG_EN
        chk("cc_err_cnt2", err_cnt, 8'h02);
        chk("cc_err_addr_aw", err_addr, 32'h0000_2222);
`endif
        wvalid = 1'b1; wlast = 1'b1;
        tick();
        wvalid = 1'b0; wlast = 1'b0;
        chk("cc_rid1", rid, 8'h01);
        chk("cc_rlast1", rlast, 1'b1);
        chk("cc_bvalid", bvalid, 1'b1);
        chk("cc_bid", bid, 8'h02);
        bready = 1'b1;
        tick();
        bready = 1'b0;
        chk("cc_arready", arready, 1'b1);
        chk("cc_rvalid_end", rvalid, 1'b0);
        chk("cc_awready", awready, 1'b1);

        // W arriving before AW is held off
        wvalid = 1'b1; wlast = 1'b1;
        for (int i = 0; i < 2; i++) begin
            chk("wfirst_wready_low", wready, 1'b0);
            tick();
        end
        awid = 8'h07; awvalid = 1'b1;
        chk("wfirst_wready_aw", wready, 1'b0);
        tick();
        awvalid = 1'b0;
        chk("wfirst_wready_high", wready, 1'b1);
        tick();
        wvalid = 1'b0; wlast = 1'b0;
        chk("wfirst_bvalid", bvalid, 1'b1);
        chk("wfirst_bid", bid, 8'h07);
        bready = 1'b1;
        tick();
        bready = 1'b0;

        // Reset during beat 2 of an ARLEN=3 read
        arid = 8'h44; arlen = 4'd3; arvalid = 1'b1; rready = 1'b1;
        tick();
        arvalid = 1'b0;
        tick();
        chk("mrst_beat2_valid", rvalid, 1'b1);
        chk("mrst_beat2_rid", rid, 8'h44);
        rst_n = 1'b0;
        #1;
        chk("mrst_rvalid", rvalid, 1'b0);
        chk("mrst_rlast", rlast, 1'b0);
        chk("mrst_rid", rid, 8'h00);
        chk("mrst_rresp", rresp, 2'b00);
        tick();
        rst_n = 1'b1;
        tick();
        chk("mrst_arready", arready, 1'b1);
        chk("mrst_rvalid_after", rvalid, 1'b0);
        arid = 8'h5A; arlen = 4'd0; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        chk("mrst_next_rid", rid, 8'h5A);
        chk("mrst_next_rlast", rlast, 1'b1);
        tick();
        chk("mrst_next_arready", arready, 1'b1);

`ifdef DEFAULT_SLAVE_ERRLOG_EN
        // Saturation of the miss counter
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        araddr = 32'h3000_0000; arlen = 4'd0; rready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            arvalid = 1'b1;
            tick();
            arvalid = 1'b0;
            tick();
        end
        chk("sat_err_cnt", err_cnt, 8'hFF);
        chk("sat_err_addr", err_addr, 32'h3000_0000);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
